// File: rtl/dmem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous dmem between NCORES data ports,
// with one-cycle read return and per-core LR/SC reservation tracking.
module dmem_rr_arbiter #(
  parameter int NCORES = 4,
  parameter int ADDRW  = 12,
  parameter int DATAW  = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic [NCORES-1:0]           re_packed_i,
  input  logic [NCORES-1:0]           we_packed_i,
  input  logic [ADDRW*NCORES-1:0]     addr_packed_i,
  input  logic [DATAW*NCORES-1:0]     wdata_packed_i,
  input  logic [(DATAW/8)*NCORES-1:0] wstrb_packed_i,
  input  logic [NCORES-1:0]           is_lr_packed_i,
  input  logic [NCORES-1:0]           is_sc_packed_i,
  output logic [DATAW*NCORES-1:0]     rdata_packed_o,
  output logic [NCORES-1:0]           stall_packed_o,
  output logic                        ram_en_o,
  output logic [DATAW/8-1:0]          ram_we_o,
  output logic [ADDRW-1:0]            ram_addr_o,
  output logic [DATAW-1:0]            ram_wdata_o,
  input  logic [DATAW-1:0]            ram_rdata_i
);

  localparam int IDW = (NCORES > 1) ? $clog2(NCORES) : 1;
  localparam int SW  = DATAW / 8;

  typedef enum logic [1:0] {K_READ, K_SC_OK, K_SC_FAIL, K_WRITE} kind_t;

  logic [ADDRW-1:0]  w_addr  [NCORES];
  logic [DATAW-1:0]  w_wdata [NCORES];
  logic [SW-1:0]     w_wstrb [NCORES];
  logic [NCORES-1:0] w_active;
  logic [NCORES-1:0] w_grant;
  logic [NCORES-1:0] w_resv_hit;
  logic              w_any;
  logic [IDW-1:0]    w_gid;
  logic [ADDRW-1:0]  w_g_addr;
  logic              w_g_wr;
  logic              w_g_sc;
  logic              w_sc_ok;
  logic              w_commit;
  kind_t             w_kind;

  logic [IDW-1:0]    r_ptr;
  logic              r_lg_v;
  logic [IDW-1:0]    r_lg_id;
  kind_t             r_lg_kind;

  assign w_active = re_packed_i | we_packed_i;

  // Scan distances from the pointer in reverse so the nearest active core wins.
  always_comb begin
    w_any = 1'b0;
    w_gid = '0;
    for (int k = NCORES - 1; k >= 0; k--) begin
      for (int i = 0; i < NCORES; i++) begin
        if (w_active[i] && (((int'(r_ptr) + k) % NCORES) == i)) begin
          w_any = 1'b1;
          w_gid = IDW'(i);
        end
      end
    end
    if (!rst_ni) w_any = 1'b0;
  end

  assign w_g_addr = w_addr[w_gid];
  assign w_g_wr   = we_packed_i[w_gid];
  assign w_g_sc   = w_g_wr & is_sc_packed_i[w_gid];
  assign w_sc_ok  = w_resv_hit[w_gid];
  assign w_commit = w_any & w_g_wr & (~w_g_sc | w_sc_ok);

  assign ram_en_o    = w_any;
  assign ram_addr_o  = w_any ? w_g_addr : '0;
  assign ram_wdata_o = w_any ? w_wdata[w_gid] : '0;
  assign ram_we_o    = w_commit ? w_wstrb[w_gid] : '0;

  always_comb begin
    w_kind = K_READ;
    if (w_g_wr) begin
      if (!w_g_sc)      w_kind = K_WRITE;
      else if (w_sc_ok) w_kind = K_SC_OK;
      else              w_kind = K_SC_FAIL;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_ptr     <= '0;
      r_lg_v    <= 1'b0;
      r_lg_id   <= '0;
      r_lg_kind <= K_READ;
    end else begin
      r_lg_v    <= w_any;
      r_lg_id   <= w_gid;
      r_lg_kind <= w_kind;
      if (w_any) r_ptr <= (w_gid == IDW'(NCORES - 1)) ? '0 : w_gid + 1'b1;
    end
  end

  for (genvar gi = 0; gi < NCORES; gi++) begin : g_core
    logic [DATAW-1:0] r_hold;
    logic [DATAW-1:0] w_rdata;
    logic             r_resv_v;
    logic [ADDRW-1:0] r_resv_a;
    logic             w_ret;

    assign w_addr[gi]  = addr_packed_i[ADDRW*gi +: ADDRW];
    assign w_wdata[gi] = wdata_packed_i[DATAW*gi +: DATAW];
    assign w_wstrb[gi] = wstrb_packed_i[SW*gi +: SW];

    assign w_grant[gi]        = w_any && (w_gid == IDW'(gi));
    assign stall_packed_o[gi] = w_active[gi] & ~w_grant[gi];
    assign w_resv_hit[gi]     = r_resv_v && (r_resv_a == w_g_addr);

    // Plain writes return nothing; their slice keeps showing the last read/SC result.
    assign w_ret = r_lg_v && (r_lg_id == IDW'(gi)) && (r_lg_kind != K_WRITE);

    always_comb begin
      w_rdata = r_hold;
      if (w_ret) begin
        case (r_lg_kind)
          K_READ:    w_rdata = ram_rdata_i;
          K_SC_OK:   w_rdata = '0;
          K_SC_FAIL: w_rdata = DATAW'(1);
          default:   w_rdata = r_hold;
        endcase
      end
    end

    assign rdata_packed_o[DATAW*gi +: DATAW] = w_rdata;

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        r_hold   <= '0;
        r_resv_v <= 1'b0;
        r_resv_a <= '0;
      end else begin
        if (w_ret) r_hold <= w_rdata;
        // A committed write to the reserved word outranks any set/clear by the grantee.
        if (w_commit && (r_resv_a == w_g_addr)) begin
          r_resv_v <= 1'b0;
        end else if (w_grant[gi] && w_g_sc) begin
          r_resv_v <= 1'b0;
        end else if (w_grant[gi] && !w_g_wr && is_lr_packed_i[gi]) begin
          r_resv_v <= 1'b1;
          r_resv_a <= w_g_addr;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_rr_arbiter.sv
// Bench for dmem_rr_arbiter: directed scenarios plus a randomized run against a
// queue-free behavioural model of the shared dmem, pointer and reservations.
module tb_dmem_rr_arbiter;

  localparam int NC = 4;
  localparam int AW = 12;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic [NC-1:0]    re, we, is_lr, is_sc;
  logic [AW-1:0]    addr  [NC];
  logic [DW-1:0]    wdata [NC];
  logic [3:0]       wstrb [NC];
  logic [AW*NC-1:0] addr_p;
  logic [DW*NC-1:0] wdata_p;
  logic [4*NC-1:0]  wstrb_p;
  logic [DW*NC-1:0] rdata_p;
  logic [NC-1:0]    stall;
  logic             ram_en;
  logic [3:0]       ram_we;
  logic [AW-1:0]    ram_addr;
  logic [DW-1:0]    ram_wdata;
  logic [DW-1:0]    ram_rdata;

  logic [DW-1:0]    mem [1<<AW];
  logic             pl_en = 1'b0;
  logic [AW-1:0]    pl_addr;
  logic [DW-1:0]    pl_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < NC; gi++) begin : g_pack
    assign addr_p[AW*gi +: AW]  = addr[gi];
    assign wdata_p[DW*gi +: DW] = wdata[gi];
    assign wstrb_p[4*gi +: 4]   = wstrb[gi];
  end

  // Single-port synchronous RAM: read data valid the cycle after the enable.
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_en) begin
      ram_rdata <= mem[ram_addr];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  dmem_rr_arbiter #(.NCORES(NC), .ADDRW(AW), .DATAW(DW)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .re_packed_i(re), .we_packed_i(we),
    .addr_packed_i(addr_p), .wdata_packed_i(wdata_p), .wstrb_packed_i(wstrb_p),
    .is_lr_packed_i(is_lr), .is_sc_packed_i(is_sc),
    .rdata_packed_o(rdata_p), .stall_packed_o(stall),
    .ram_en_o(ram_en), .ram_we_o(ram_we), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_rdata_i(ram_rdata)
  );

  task automatic idle();
    re = '0; we = '0; is_lr = '0; is_sc = '0;
    for (int i = 0; i < NC; i++) begin
      addr[i] = '0; wdata[i] = '0; wstrb[i] = '0;
    end
  endtask

  task automatic poke(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_v, input logic [DW-1:0] new_v,
                                          input logic [3:0] strb);
    logic [DW-1:0] r;
    r = old_v;
    for (int b = 0; b < 4; b++) if (strb[b]) r[8*b +: 8] = new_v[8*b +: 8];
    return r;
  endfunction

  task automatic test_reset();
    re[0] = 1'b1; re[2] = 1'b1;
    #1;
    total++; if (stall !== 4'b0101) begin bad++; $display("FAIL reset_stall got=%b exp=0101", stall); end
    total++; if (ram_en !== 1'b0 || ram_we !== 4'h0) begin bad++; $display("FAIL reset_ram got_en=%b got_we=%h exp=0/0", ram_en, ram_we); end
    total++; if (rdata_p !== '0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata_p); end
    @(negedge clk);
    rst_n = 1'b1;
    idle();
    @(negedge clk);
  endtask

  task automatic test_contention();
    logic [NC-1:0] exp_act;
    int stalls3;
    for (int i = 0; i < NC; i++) poke(AW'(256 + i), DW'(32'hC0DE0000 + i));
    for (int i = 0; i < NC; i++) begin re[i] = 1'b1; addr[i] = AW'(256 + i); end
    stalls3 = 0;
    for (int c = 0; c < NC; c++) begin
      #1;
      exp_act = 4'hF << c;
      total++; if (stall !== (exp_act & ~(4'b0001 << c))) begin bad++; $display("FAIL contention_stall cyc=%0d got=%b exp=%b", c, stall, exp_act & ~(4'b0001 << c)); end
      total++; if (ram_addr !== AW'(256 + c)) begin bad++; $display("FAIL contention_addr cyc=%0d got=%h exp=%h", c, ram_addr, AW'(256 + c)); end
      if (c > 0) begin
        total++; if (rdata_p[DW*(c-1) +: DW] !== DW'(32'hC0DE0000 + c - 1)) begin bad++; $display("FAIL contention_rdata core=%0d got=%h exp=%h", c - 1, rdata_p[DW*(c-1) +: DW], DW'(32'hC0DE0000 + c - 1)); end
      end
      if (stall[3]) stalls3++;
      @(negedge clk);
      re[c] = 1'b0;
    end
    #1;
    total++; if (rdata_p[DW*3 +: DW] !== 32'hC0DE0003) begin bad++; $display("FAIL contention_rdata3 got=%h exp=c0de0003", rdata_p[DW*3 +: DW]); end
    total++; if (stalls3 != 3) begin bad++; $display("FAIL contention_wait3 got=%0d exp=3", stalls3); end
    @(negedge clk);
  endtask

  task automatic test_single_read();
    poke(12'h010, 32'hDEADBEEF);
    poke(12'h011, 32'h12345678);
    re[0] = 1'b1; addr[0] = 12'h010;
    #1;
    total++; if (stall !== 4'b0000 || ram_en !== 1'b1 || ram_addr !== 12'h010 || ram_we !== 4'h0) begin
      bad++; $display("FAIL single_grant got_stall=%b en=%b addr=%h we=%h exp=0000/1/010/0", stall, ram_en, ram_addr, ram_we);
    end
    @(negedge clk);
    re[0] = 1'b0; re[1] = 1'b1; addr[1] = 12'h011;
    #1;
    total++; if (rdata_p[DW*0 +: DW] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_rdata got=%h exp=deadbeef", rdata_p[DW*0 +: DW]); end
    @(negedge clk);
    re[1] = 1'b0;
    #1;
    total++; if (rdata_p[DW*0 +: DW] !== 32'hDEADBEEF) begin bad++; $display("FAIL single_hold got=%h exp=deadbeef", rdata_p[DW*0 +: DW]); end
    total++; if (rdata_p[DW*1 +: DW] !== 32'h12345678) begin bad++; $display("FAIL single_rdata1 got=%h exp=12345678", rdata_p[DW*1 +: DW]); end
    @(negedge clk);
  endtask

  task automatic test_fairness();
    logic [NC-1:0] exp_stall;
    re[1] = 1'b1; addr[1] = 12'h010;
    re[2] = 1'b1; addr[2] = 12'h011;
    for (int c = 0; c < 8; c++) begin
      #1;
      exp_stall = (c % 2 == 0) ? 4'b0010 : 4'b0100;
      total++; if (stall !== exp_stall) begin bad++; $display("FAIL fairness cyc=%0d got=%b exp=%b", c, stall, exp_stall); end
      @(negedge clk);
    end
    idle();
    @(negedge clk);
  endtask

  task automatic test_lrsc_ok();
    poke(12'h020, 32'hAAAA5555);
    re[1] = 1'b1; is_lr[1] = 1'b1; addr[1] = 12'h020;
    #1;
    total++; if (stall !== 4'b0000) begin bad++; $display("FAIL lr_grant got=%b exp=0000", stall); end
    @(negedge clk);
    re[1] = 1'b0; is_lr[1] = 1'b0;
    we[1] = 1'b1; is_sc[1] = 1'b1; wdata[1] = 32'd5; wstrb[1] = 4'hF;
    #1;
    total++; if (rdata_p[DW*1 +: DW] !== 32'hAAAA5555) begin bad++; $display("FAIL lr_rdata got=%h exp=aaaa5555", rdata_p[DW*1 +: DW]); end
    total++; if (ram_we !== 4'hF) begin bad++; $display("FAIL sc_ok_we got=%h exp=f", ram_we); end
    @(negedge clk);
    idle();
    #1;
    total++; if (rdata_p[DW*1 +: DW] !== 32'd0) begin bad++; $display("FAIL sc_ok_result got=%h exp=0", rdata_p[DW*1 +: DW]); end
    total++; if (mem[12'h020] !== 32'd5) begin bad++; $display("FAIL sc_ok_mem got=%h exp=5", mem[12'h020]); end
    @(negedge clk);
  endtask

  task automatic test_lrsc_fail();
    re[0] = 1'b1; is_lr[0] = 1'b1; addr[0] = 12'h020;
    @(negedge clk);
    idle();
    we[2] = 1'b1; addr[2] = 12'h020; wdata[2] = 32'h77; wstrb[2] = 4'hF;
    #1;
    total++; if (rdata_p[DW*0 +: DW] !== 32'd5) begin bad++; $display("FAIL lr0_rdata got=%h exp=5", rdata_p[DW*0 +: DW]); end
    @(negedge clk);
    idle();
    we[0] = 1'b1; is_sc[0] = 1'b1; addr[0] = 12'h020; wdata[0] = 32'd9; wstrb[0] = 4'hF;
    #1;
    total++; if (ram_en !== 1'b1 || ram_we !== 4'h0) begin bad++; $display("FAIL sc_fail_we got_en=%b we=%h exp=1/0", ram_en, ram_we); end
    @(negedge clk);
    idle();
    #1;
    total++; if (rdata_p[DW*0 +: DW] !== 32'd1) begin bad++; $display("FAIL sc_fail_result got=%h exp=1", rdata_p[DW*0 +: DW]); end
    total++; if (mem[12'h020] !== 32'h77) begin bad++; $display("FAIL sc_fail_mem got=%h exp=77", mem[12'h020]); end
    @(negedge clk);
  endtask

  task automatic test_strobe();
    poke(12'h030, 32'h11223344);
    we[3] = 1'b1; addr[3] = 12'h030; wdata[3] = 32'h00AA0000; wstrb[3] = 4'b0100;
    #1;
    total++; if (ram_we !== 4'b0100) begin bad++; $display("FAIL strobe_we got=%b exp=0100", ram_we); end
    @(negedge clk);
    idle();
    #1;
    total++; if (mem[12'h030] !== 32'h11AA3344) begin bad++; $display("FAIL strobe_mem got=%h exp=11aa3344", mem[12'h030]); end
    total++; if (rdata_p[DW*3 +: DW] !== 32'hC0DE0003) begin bad++; $display("FAIL strobe_hold got=%h exp=c0de0003", rdata_p[DW*3 +: DW]); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    poke(12'h040, 32'hBEEF0040);
    re[2] = 1'b1; is_lr[2] = 1'b1; addr[2] = 12'h040;
    @(negedge clk);
    idle();
    for (int i = 0; i < NC; i++) begin re[i] = 1'b1; addr[i] = AW'(256 + i); end
    #1;
    total++; if (stall !== 4'b0111) begin bad++; $display("FAIL resetmid_pre got=%b exp=0111", stall); end
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    total++; if (stall !== 4'b1111 || ram_en !== 1'b0 || ram_we !== 4'h0) begin bad++; $display("FAIL resetmid_stall got=%b en=%b we=%h exp=1111/0/0", stall, ram_en, ram_we); end
    total++; if (rdata_p !== '0) begin bad++; $display("FAIL resetmid_rdata got=%h exp=0", rdata_p); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (stall !== 4'b1110) begin bad++; $display("FAIL resetmid_ptr got=%b exp=1110", stall); end
    @(negedge clk);
    idle();
    we[2] = 1'b1; is_sc[2] = 1'b1; addr[2] = 12'h040; wdata[2] = 32'h99; wstrb[2] = 4'hF;
    #1;
    total++; if (ram_we !== 4'h0) begin bad++; $display("FAIL resetmid_resv got=%h exp=0", ram_we); end
    @(negedge clk);
    idle();
    #1;
    total++; if (rdata_p[DW*2 +: DW] !== 32'd1) begin bad++; $display("FAIL resetmid_sc got=%h exp=1", rdata_p[DW*2 +: DW]); end
    total++; if (rdata_p[DW*3 +: DW] !== 32'd0) begin bad++; $display("FAIL resetmid_drop got=%h exp=0", rdata_p[DW*3 +: DW]); end
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [DW-1:0] m_mem [8];
    logic [DW-1:0] m_hold [NC];
    bit            m_rv [NC];
    logic [AW-1:0] m_ra [NC];
    int            m_ptr;
    bit            p_v [NC];
    int            p_kind [NC];
    logic [AW-1:0] p_addr [NC];
    logic [DW-1:0] p_wdata [NC];
    logic [3:0]    p_wstrb [NC];
    logic [NC-1:0] exp_stall;
    logic [DW*NC-1:0] exp_rd;
    int w;
    bit ok;

    idle();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    m_ptr = 0;
    for (int i = 0; i < NC; i++) begin
      m_hold[i] = '0; m_rv[i] = 1'b0; m_ra[i] = '0; p_v[i] = 1'b0; p_kind[i] = 0;
      p_addr[i] = '0; p_wdata[i] = '0; p_wstrb[i] = '0;
    end
    for (int a = 0; a < 8; a++) begin
      m_mem[a] = $urandom;
      poke(AW'(a), m_mem[a]);
    end

    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int i = 0; i < NC; i++) begin
        if (!p_v[i] && ($urandom_range(0, 1) == 1)) begin
          p_v[i] = 1'b1;
          p_kind[i] = int'($urandom_range(0, 3));
          p_addr[i] = AW'($urandom_range(0, 7));
          p_wdata[i] = $urandom;
          p_wstrb[i] = 4'($urandom_range(1, 15));
        end
        re[i]    = p_v[i] && (p_kind[i] == 0 || p_kind[i] == 2);
        we[i]    = p_v[i] && (p_kind[i] == 1 || p_kind[i] == 3);
        is_lr[i] = p_v[i] && (p_kind[i] == 2);
        is_sc[i] = p_v[i] && (p_kind[i] == 3);
        addr[i] = p_addr[i]; wdata[i] = p_wdata[i]; wstrb[i] = p_wstrb[i];
      end
      #1;
      w = -1;
      for (int k = 0; k < NC; k++) if (w < 0 && p_v[(m_ptr + k) % NC]) w = (m_ptr + k) % NC;
      for (int i = 0; i < NC; i++) begin
        exp_stall[i] = p_v[i] && (i != w);
        exp_rd[DW*i +: DW] = m_hold[i];
      end
      total++; if (stall !== exp_stall) begin bad++; $display("FAIL rand_stall cyc=%0d got=%b exp=%b", cyc, stall, exp_stall); end
      total++; if (ram_en !== (w >= 0)) begin bad++; $display("FAIL rand_en cyc=%0d got=%b exp=%b", cyc, ram_en, w >= 0); end
      total++; if (rdata_p !== exp_rd) begin bad++; $display("FAIL rand_rdata cyc=%0d got=%h exp=%h", cyc, rdata_p, exp_rd); end
      if (w >= 0) begin
        case (p_kind[w])
          0, 2: begin
            m_hold[w] = m_mem[p_addr[w]];
            if (p_kind[w] == 2) begin m_rv[w] = 1'b1; m_ra[w] = p_addr[w]; end
          end
          default: begin
            ok = (p_kind[w] == 1) || (m_rv[w] && m_ra[w] == p_addr[w]);
            if (p_kind[w] == 3) begin
              m_rv[w] = 1'b0;
              m_hold[w] = ok ? 32'd0 : 32'd1;
            end
            if (ok) begin
              m_mem[p_addr[w]] = merge(m_mem[p_addr[w]], p_wdata[w], p_wstrb[w]);
              for (int j = 0; j < NC; j++) if (m_ra[j] == p_addr[w]) m_rv[j] = 1'b0;
            end
          end
        endcase
        m_ptr = (w + 1) % NC;
        p_v[w] = 1'b0;
      end
      @(negedge clk);
    end
    idle();
    #1;
    for (int i = 0; i < NC; i++) exp_rd[DW*i +: DW] = m_hold[i];
    total++; if (rdata_p !== exp_rd) begin bad++; $display("FAIL rand_final_rdata got=%h exp=%h", rdata_p, exp_rd); end
    for (int a = 0; a < 8; a++) begin
      total++; if (mem[a] !== m_mem[a]) begin bad++; $display("FAIL rand_mem addr=%0d got=%h exp=%h", a, mem[a], m_mem[a]); end
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    pl_addr = '0;
    pl_data = '0;
    test_reset();
    test_contention();
    test_single_read();
    test_fairness();
    test_lrsc_ok();
    test_lrsc_fail();
    test_strobe();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
